mano_sequencer: RTL and testbench

- Timing-and-sequence controller for the 8-bit Mano datapath. Replaces the free-running sequence counter, 3x8 decoder and IR decode path with a single sequenced block.
- Holds the instruction register and drives the one-hot timing signals T, the opcode decode D, the indirect bit I and the register-reference bits B consumed by the control unit.
- Adds run/halt control, a memory-ready handshake that stalls the timing chain, a wait timeout, and an instruction counter.

---
 rtl/mano_sequencer_pkg.sv | 38 +++
 rtl/mano_sequencer_if.sv | 30 +++
 rtl/mano_seq_decode.sv | 19 +
 rtl/mano_sequencer.sv | 123 ++++++++++++
 tb/tb_mano_sequencer.sv | 276 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/mano_sequencer_pkg.sv
// rtl/mano_sequencer_pkg.sv - shared types and constants for the Mano timing/sequence controller
package mano_sequencer_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } seq_state_t;

    localparam int T0 = 0;
    localparam int T1 = 1;
    localparam int T2 = 2;
    localparam int T3 = 3;
    localparam int T4 = 4;
    localparam int T5 = 5;
    localparam int T6 = 6;
    localparam int T7 = 7;

    localparam logic [2:0] OP_AND = 3'd0;
    localparam logic [2:0] OP_ADD = 3'd1;
    localparam logic [2:0] OP_LDA = 3'd2;
    localparam logic [2:0] OP_STA = 3'd3;
    localparam logic [2:0] OP_BUN = 3'd4;
    localparam logic [2:0] OP_OR  = 3'd5;
    localparam logic [2:0] OP_ISZ = 3'd6;
    localparam logic [2:0] OP_REG = 3'd7;

    // Register-reference bit positions within B
    localparam int INC = 0;
    localparam int HLT = 1;
    localparam int CMA = 2;
    localparam int CLA = 3;

    function automatic logic [7:0] onehot8(input logic [2:0] idx);
        onehot8 = 8'b1 << idx;
    endfunction

endpackage

// File: rtl/mano_sequencer_if.sv
// rtl/mano_sequencer_if.sv - control-unit <-> sequencer signal bundle
interface mano_sequencer_if #(parameter int CNT_W = 16);

    logic             run;
    logic             resume;
    logic [7:0]       bus_in;
    logic             ld_ir;
    logic             clr_sc;
    logic             mem_rd;
    logic             mem_ack;
    logic [7:0]       T;
    logic [7:0]       D;
    logic             I;
    logic [7:0]       B;
    logic             step_en;
    logic             halted;
    logic             seq_err;
    logic [CNT_W-1:0] instr_cnt;

    modport master (
        output run, resume, bus_in, ld_ir, clr_sc, mem_rd, mem_ack,
        input  T, D, I, B, step_en, halted, seq_err, instr_cnt
    );

    modport slave (
        input  run, resume, bus_in, ld_ir, clr_sc, mem_rd, mem_ack,
        output T, D, I, B, step_en, halted, seq_err, instr_cnt
    );

endinterface

// File: rtl/mano_seq_decode.sv
// rtl/mano_seq_decode.sv - combinational IR decode into D/I/B plus the HLT instruction match
module mano_seq_decode
    import mano_sequencer_pkg::*;
(
    input  logic [7:0] ir,
    output logic [7:0] d,
    output logic       i,
    output logic [7:0] b,
    output logic       hlt_match
);

    assign d = onehot8(ir[6:4]);
    assign i = ir[7];
    assign b = {4'b0000, ir[3:0]};

    // Timing and step qualification are applied by the sequencer
    assign hlt_match = d[OP_REG] & ~i & b[HLT];

endmodule

// File: rtl/mano_sequencer.sv
// rtl/mano_sequencer.sv - timing/sequence controller: IR, one-hot T, run/halt, memory stall and timeout
module mano_sequencer
    import mano_sequencer_pkg::*;
#(
    parameter int CNT_W    = 16,
    parameter int MAX_WAIT = 15
) (
    input  logic             clk,
    input  logic             reset,
    mano_sequencer_if.slave  bus
);

    localparam logic [7:0] WAIT_LAST = 8'(MAX_WAIT - 1);

    seq_state_t       state, state_n;
    logic [2:0]       sc, sc_n;
    logic [7:0]       ir;
    logic [7:0]       wait_cnt;
    logic             seq_err;
    logic [CNT_W-1:0] instr_cnt;

    logic [7:0] t_vec, d_vec, b_vec;
    logic       i_bit, hlt_match;
    logic       stall, step_en, timeout, halt_hit;
    logic       err_set, cnt_inc;

    mano_seq_decode u_decode (
        .ir        (ir),
        .d         (d_vec),
        .i         (i_bit),
        .b         (b_vec),
        .hlt_match (hlt_match)
    );

    // T depends only on registered state, keeping mem_ack off the timing path
    always_comb begin
        t_vec    = (state == RUN) ? onehot8(sc) : 8'h00;
        stall    = (state == RUN) & bus.mem_rd & ~bus.mem_ack;
        step_en  = (state == RUN) & ~stall;
        timeout  = stall & (wait_cnt == WAIT_LAST);
        halt_hit = t_vec[T3] & hlt_match & step_en;
    end

    always_comb begin
        state_n = state;
        sc_n    = sc;
        err_set = 1'b0;
        cnt_inc = 1'b0;
        case (state)
            IDLE: begin
                if (bus.run) begin
                    state_n = RUN;
                    sc_n    = 3'd0;
                end
            end
            RUN: begin
                if (timeout) begin
                    state_n = HALT;
                    err_set = 1'b1;
                end else if (step_en) begin
                    if (halt_hit) begin
                        state_n = HALT;
                        sc_n    = 3'd0;
                        cnt_inc = 1'b1;
                    end else if (bus.clr_sc) begin
                        sc_n    = 3'd0;
                        cnt_inc = 1'b1;
                        if (!bus.run) begin
                            state_n = IDLE;
                        end
                    end else begin
                        sc_n    = sc + 3'd1;
                        err_set = (sc == 3'd7);
                    end
                end
            end
            HALT: begin
                if (bus.resume) begin
                    state_n = RUN;
                    sc_n    = 3'd0;
                end
            end
            default: begin
                state_n = IDLE;
                sc_n    = 3'd0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            sc        <= 3'd0;
            ir        <= 8'h00;
            wait_cnt  <= 8'd0;
            seq_err   <= 1'b0;
            instr_cnt <= '0;
        end else begin
            state    <= state_n;
            sc       <= sc_n;
            wait_cnt <= stall ? wait_cnt + 8'd1 : 8'd0;
            if (bus.ld_ir & step_en) begin
                ir <= bus.bus_in;
            end
            if (err_set) begin
                seq_err <= 1'b1;
            end
            if (cnt_inc) begin
                instr_cnt <= instr_cnt + CNT_W'(1);
            end
        end
    end

    assign bus.T         = t_vec;
    assign bus.D         = d_vec;
    assign bus.I         = i_bit;
    assign bus.B         = b_vec;
    assign bus.step_en   = step_en;
    assign bus.halted    = (state == HALT);
    assign bus.seq_err   = seq_err;
    assign bus.instr_cnt = instr_cnt;

endmodule

// File: tb/tb_mano_sequencer.sv
// tb/tb_mano_sequencer.sv - self-checking bench for mano_sequencer
module tb_mano_sequencer;

    localparam int CNT_W    = 16;
    localparam int MAX_WAIT = 15;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   n_pass  = 0;
    int   n_total = 0;

    mano_sequencer_if #(.CNT_W(CNT_W)) bus ();

    mano_sequencer #(.CNT_W(CNT_W), .MAX_WAIT(MAX_WAIT)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        run;
        logic        ld_ir;
        logic        clr_sc;
        logic        mem_rd;
        logic        mem_ack;
        logic [7:0]  bus_in;
        logic [7:0]  t;
        logic        step;
        logic [7:0]  d;
        logic        i;
        logic [7:0]  b;
        logic [15:0] cnt;
    } vec_t;

    vec_t vecs [13];

    int          m_mode;
    int          m_phase;
    logic [7:0]  m_ir;
    int          m_wait;
    logic        m_err;
    logic [15:0] m_cnt;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic drive(input logic run, input logic resume, input logic [7:0] bin,
                         input logic ld, input logic clr, input logic rd, input logic ack);
        bus.run     = run;
        bus.resume  = resume;
        bus.bus_in  = bin;
        bus.ld_ir   = ld;
        bus.clr_sc  = clr;
        bus.mem_rd  = rd;
        bus.mem_ack = ack;
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        drive(0, 0, 8'h00, 0, 0, 0, 1);
        @(negedge clk);
        @(negedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic model_reset();
        m_mode  = 0;
        m_phase = 0;
        m_ir    = 8'h00;
        m_wait  = 0;
        m_err   = 1'b0;
        m_cnt   = 16'd0;
    endtask

    task automatic compare_model(input string tag);
        logic       stalled;
        logic [7:0] op_shift;
        stalled  = (m_mode == 1) && bus.mem_rd && !bus.mem_ack;
        op_shift = 8'h01 << m_ir[6:4];
        chk({tag, " T"}, bus.T, (m_mode == 1) ? (32'h1 << m_phase) : 32'h0);
        chk({tag, " D"}, bus.D, op_shift);
        chk({tag, " I"}, bus.I, m_ir[7]);
        chk({tag, " B"}, bus.B, {4'b0000, m_ir[3:0]});
        chk({tag, " step_en"}, bus.step_en, (m_mode == 1) && !stalled);
        chk({tag, " halted"}, bus.halted, m_mode == 2);
        chk({tag, " seq_err"}, bus.seq_err, m_err);
        chk({tag, " instr_cnt"}, bus.instr_cnt, m_cnt);
    endtask

    // Applies the rules for one rising edge to the abstract model, using the inputs now on the bus
    task automatic model_advance();
        logic stalled, stepping, hlt_instr;
        stalled   = (m_mode == 1) && bus.mem_rd && !bus.mem_ack;
        stepping  = (m_mode == 1) && !stalled;
        hlt_instr = (m_ir[7] == 1'b0) && (m_ir[6:4] == 3'd7) && m_ir[1];
        if (m_mode == 0) begin
            if (bus.run) begin m_mode = 1; m_phase = 0; end
        end else if (m_mode == 2) begin
            if (bus.resume) begin m_mode = 1; m_phase = 0; end
        end else begin
            if (stalled && (m_wait + 1 == MAX_WAIT)) begin
                m_mode = 2;
                m_err  = 1'b1;
            end else if (stepping) begin
                if (m_phase == 3 && hlt_instr) begin
                    m_mode = 2; m_phase = 0; m_cnt++;
                end else if (bus.clr_sc) begin
                    m_phase = 0; m_cnt++;
                    if (!bus.run) m_mode = 0;
                end else begin
                    if (m_phase == 7) m_err = 1'b1;
                    m_phase = (m_phase + 1) % 8;
                end
            end
        end
        m_wait = stalled ? m_wait + 1 : 0;
        if (stepping && bus.ld_ir) m_ir = bus.bus_in;
    endtask

    initial begin
        int burst;
        logic rd, ack;

        //          run ld  clr rd  ack bus     T      st  D      I  B      cnt
        vecs[0]  = '{1, 0, 0, 0, 1, 8'h00, 8'h00, 0, 8'h01, 0, 8'h00, 16'd0};
        vecs[1]  = '{1, 0, 0, 0, 1, 8'h00, 8'h01, 1, 8'h01, 0, 8'h00, 16'd0};
        vecs[2]  = '{1, 1, 0, 0, 1, 8'h91, 8'h02, 1, 8'h01, 0, 8'h00, 16'd0};
        vecs[3]  = '{1, 0, 0, 0, 1, 8'h00, 8'h04, 1, 8'h02, 1, 8'h01, 16'd0};
        vecs[4]  = '{1, 0, 0, 0, 1, 8'h00, 8'h08, 1, 8'h02, 1, 8'h01, 16'd0};
        vecs[5]  = '{1, 0, 0, 0, 1, 8'h00, 8'h10, 1, 8'h02, 1, 8'h01, 16'd0};
        vecs[6]  = '{1, 0, 1, 0, 1, 8'h00, 8'h20, 1, 8'h02, 1, 8'h01, 16'd0};
        vecs[7]  = '{1, 0, 0, 0, 1, 8'h00, 8'h01, 1, 8'h02, 1, 8'h01, 16'd1};
        vecs[8]  = '{1, 1, 0, 1, 0, 8'h55, 8'h02, 0, 8'h02, 1, 8'h01, 16'd1};
        vecs[9]  = '{1, 1, 0, 1, 0, 8'h55, 8'h02, 0, 8'h02, 1, 8'h01, 16'd1};
        vecs[10] = '{1, 1, 0, 1, 0, 8'h55, 8'h02, 0, 8'h02, 1, 8'h01, 16'd1};
        vecs[11] = '{1, 1, 0, 1, 1, 8'h55, 8'h02, 1, 8'h02, 1, 8'h01, 16'd1};
        vecs[12] = '{1, 0, 0, 0, 1, 8'h00, 8'h04, 1, 8'h20, 0, 8'h05, 16'd1};

        do_reset();
        chk("reset T", bus.T, 8'h00);
        chk("reset D", bus.D, 8'h01);
        chk("reset I", bus.I, 1'b0);
        chk("reset B", bus.B, 8'h00);
        chk("reset step_en", bus.step_en, 1'b0);
        chk("reset halted", bus.halted, 1'b0);
        chk("reset seq_err", bus.seq_err, 1'b0);
        chk("reset instr_cnt", bus.instr_cnt, 16'd0);

        for (int k = 0; k < 13; k++) begin
            drive(vecs[k].run, 0, vecs[k].bus_in, vecs[k].ld_ir, vecs[k].clr_sc,
                  vecs[k].mem_rd, vecs[k].mem_ack);
            #1;
            chk($sformatf("vec%0d T", k), bus.T, vecs[k].t);
            chk($sformatf("vec%0d step_en", k), bus.step_en, vecs[k].step);
            chk($sformatf("vec%0d D", k), bus.D, vecs[k].d);
            chk($sformatf("vec%0d I", k), bus.I, vecs[k].i);
            chk($sformatf("vec%0d B", k), bus.B, vecs[k].b);
            chk($sformatf("vec%0d instr_cnt", k), bus.instr_cnt, vecs[k].cnt);
            chk($sformatf("vec%0d seq_err", k), bus.seq_err, 1'b0);
            tick();
        end

        // HLT instruction at T3 together with clr_sc, then resume
        do_reset();
        drive(1, 0, 8'h00, 0, 0, 0, 1); tick();
        tick();
        drive(1, 0, 8'h72, 1, 0, 0, 1); tick();
        drive(1, 0, 8'h00, 0, 0, 0, 1); tick();
        drive(1, 0, 8'h00, 0, 1, 0, 1); #1;
        chk("hlt T3", bus.T, 8'h08);
        chk("hlt step_en", bus.step_en, 1'b1);
        tick();
        drive(1, 0, 8'h00, 0, 0, 0, 1); #1;
        chk("hlt halted", bus.halted, 1'b1);
        chk("hlt T", bus.T, 8'h00);
        chk("hlt instr_cnt", bus.instr_cnt, 16'd1);
        chk("hlt D", bus.D, 8'h80);
        chk("hlt B", bus.B, 8'h02);
        tick();
        chk("hlt held", bus.halted, 1'b1);
        chk("hlt held T", bus.T, 8'h00);
        drive(1, 1, 8'h00, 0, 0, 0, 1); tick();
        drive(1, 0, 8'h00, 0, 0, 0, 1); #1;
        chk("resume T", bus.T, 8'h01);
        chk("resume halted", bus.halted, 1'b0);

        // Wait timeout after MAX_WAIT consecutive stalls
        do_reset();
        drive(1, 0, 8'h00, 0, 0, 0, 1); tick();
        tick();
        drive(1, 0, 8'h00, 0, 0, 1, 0);
        for (int k = 0; k < MAX_WAIT; k++) begin
            #1;
            chk($sformatf("stall%0d T", k), bus.T, 8'h02);
            chk($sformatf("stall%0d halted", k), bus.halted, 1'b0);
            chk($sformatf("stall%0d seq_err", k), bus.seq_err, 1'b0);
            tick();
        end
        chk("timeout halted", bus.halted, 1'b1);
        chk("timeout seq_err", bus.seq_err, 1'b1);
        chk("timeout T", bus.T, 8'h00);

        // Eight steps without clr_sc wrap T, then asynchronous reset mid-T4
        do_reset();
        drive(1, 0, 8'h00, 0, 0, 0, 1); tick();
        drive(1, 0, 8'h3C, 1, 0, 0, 1); tick();
        drive(1, 0, 8'h00, 0, 0, 0, 1);
        for (int k = 1; k < 8; k++) begin
            if (k == 7) begin
                #1;
                chk("wrap T7", bus.T, 8'h80);
                chk("wrap pre seq_err", bus.seq_err, 1'b0);
            end
            tick();
        end
        chk("wrap T", bus.T, 8'h01);
        chk("wrap seq_err", bus.seq_err, 1'b1);
        for (int k = 0; k < 4; k++) tick();
        chk("mid T4", bus.T, 8'h10);
        chk("mid D", bus.D, 8'h08);
        #1;
        reset = 1'b1;
        #1;
        chk("async T", bus.T, 8'h00);
        chk("async D", bus.D, 8'h01);
        chk("async B", bus.B, 8'h00);
        chk("async seq_err", bus.seq_err, 1'b0);
        chk("async instr_cnt", bus.instr_cnt, 16'd0);
        chk("async step_en", bus.step_en, 1'b0);

        // Randomised run against the reference model
        do_reset();
        model_reset();
        burst = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if ($urandom_range(0, 299) == 0) begin
                reset = 1'b1;
                #1;
                model_reset();
                compare_model($sformatf("rnd%0d rst", cyc));
                tick();
                reset = 1'b0;
                continue;
            end
            if (burst > 0) begin
                rd = 1'b1; ack = 1'b0; burst--;
            end else begin
                rd  = 1'($urandom_range(0, 1));
                ack = ($urandom_range(0, 3) != 0);
                if ($urandom_range(0, 79) == 0) burst = $urandom_range(10, 20);
            end
            drive($urandom_range(0, 15) != 0, $urandom_range(0, 7) == 0,
                  ($urandom_range(0, 3) == 0) ? 8'h72 : 8'($urandom),
                  1'($urandom_range(0, 1)), $urandom_range(0, 4) == 0, rd, ack);
            #1;
            compare_model($sformatf("rnd%0d", cyc));
            model_advance();
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
